mont_cmd_controller: RTL and testbench

Command front-end and sequencer for the RSA accelerator, generalising the wrapper to NUM_CORES Montgomery cores and WORD_LEN-bit operands. Accepts 32-bit commands from the processor on port1, loads operands from the BRAM interface into per-core operand banks, starts exponentiation or multiplication on a selectable subset of cores, writes results back, and reports completion plus status and cycle count on port2. The Montgomery cores are external; this block owns only control, operand storage and handshakes.

---
 rtl/mont_cmd_controller_pkg.sv | 25 ++
 rtl/mont_cmd_controller_if.sv | 30 +++
 rtl/mont_operand_bank.sv | 42 ++++
 rtl/mont_cmd_controller.sv | 116 +++++++++++
 tb/tb_mont_cmd_controller.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mont_cmd_controller_pkg.sv
// mont_ctrl_pkg: opcodes, FSM states and command/status field layout shared by the controller
package mont_ctrl_pkg;
  localparam int CYCLE_W = 16;
  localparam int CMD_OP_LSB = 0;
  localparam int CMD_OP_W = 4;
  localparam int CMD_MASK_LSB = 8;
  localparam int ST_OP_LSB = 0;
  localparam int ST_ERR_BIT = 8;
  localparam int ST_CYC_LSB = 16;
  localparam logic [3:0] OP_READ_X = 4'd0;
  localparam logic [3:0] OP_READ_E = 4'd1;
  localparam logic [3:0] OP_READ_M = 4'd2;
  localparam logic [3:0] OP_READ_R2M = 4'd3;
  localparam logic [3:0] OP_READ_RM = 4'd4;
  localparam logic [3:0] OP_EXP = 4'd5;
  localparam logic [3:0] OP_MUL = 4'd6;
  localparam logic [3:0] OP_WRITE = 4'd7;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_WRITE, S_DONE} state_e;
  function automatic logic [31:0] status_word(input logic [CYCLE_W-1:0] cycles, input logic err, input logic [3:0] op);
    status_word = '0;
    status_word[ST_CYC_LSB +: CYCLE_W] = cycles;
    status_word[ST_ERR_BIT] = err;
    status_word[ST_OP_LSB +: CMD_OP_W] = op;
  endfunction
endpackage

// File: rtl/mont_cmd_controller_if.sv
// mont_cmd_controller_if: processor ports, BRAM operand/result path and core handshakes
interface mont_cmd_controller_if #(parameter int WORD_LEN = 512, parameter int NUM_CORES = 2);
  localparam int BW = WORD_LEN * NUM_CORES;
  logic [31:0] port1_din;
  logic port1_valid;
  logic port1_read;
  logic [31:0] port2_dout;
  logic port2_valid;
  logic port2_read;
  logic [BW-1:0] bram_din;
  logic bram_din_valid;
  logic [BW-1:0] bram_dout;
  logic [NUM_CORES-1:0] bram_dout_valid;
  logic bram_dout_read;
  logic [NUM_CORES-1:0] core_start;
  logic core_mode;
  logic [BW-1:0] core_x, core_e, core_m, core_r2m, core_rm, core_result;
  logic [NUM_CORES-1:0] core_done;
  logic busy;
  modport slave (
    input port1_din, port1_valid, port2_read, bram_din, bram_din_valid, bram_dout_read, core_result, core_done,
    output port1_read, port2_dout, port2_valid, bram_dout, bram_dout_valid, core_start, core_mode,
    output core_x, core_e, core_m, core_r2m, core_rm, busy
  );
  modport master (
    output port1_din, port1_valid, port2_read, bram_din, bram_din_valid, bram_dout_read, core_result, core_done,
    input port1_read, port2_dout, port2_valid, bram_dout, bram_dout_valid, core_start, core_mode,
    input core_x, core_e, core_m, core_r2m, core_rm, busy
  );
endinterface

// File: rtl/mont_operand_bank.sv
// mont_operand_bank: one core's five operand registers plus its captured result
module mont_operand_bank import mont_ctrl_pkg::*; #(
  parameter int WORD_LEN = 512
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_we,
  input  logic [3:0]          i_sel,
  input  logic [WORD_LEN-1:0] i_din,
  input  logic                i_res_we,
  input  logic [WORD_LEN-1:0] i_res,
  output logic [WORD_LEN-1:0] o_x,
  output logic [WORD_LEN-1:0] o_e,
  output logic [WORD_LEN-1:0] o_m,
  output logic [WORD_LEN-1:0] o_r2m,
  output logic [WORD_LEN-1:0] o_rm,
  output logic [WORD_LEN-1:0] o_result
);
  logic [WORD_LEN-1:0] r_x, r_e, r_m, r_r2m, r_rm, r_res;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_x <= '0;
      r_e <= '0;
      r_m <= '0;
      r_r2m <= '0;
      r_rm <= '0;
      r_res <= '0;
    end else begin
      if (i_we && i_sel == OP_READ_X) r_x <= i_din;
      if (i_we && i_sel == OP_READ_E) r_e <= i_din;
      if (i_we && i_sel == OP_READ_M) r_m <= i_din;
      if (i_we && i_sel == OP_READ_R2M) r_r2m <= i_din;
      if (i_we && i_sel == OP_READ_RM) r_rm <= i_din;
      if (i_res_we) r_res <= i_res;
    end
  assign o_x = r_x;
  assign o_e = r_e;
  assign o_m = r_m;
  assign o_r2m = r_r2m;
  assign o_rm = r_rm;
  assign o_result = r_res;
endmodule

// File: rtl/mont_cmd_controller.sv
// mont_cmd_controller: command sequencer for NUM_CORES Montgomery cores
// Decodes port1 commands, fills operand banks, runs the cores and reports status on port2.
module mont_cmd_controller import mont_ctrl_pkg::*; #(
  parameter int WORD_LEN = 512,
  parameter int NUM_CORES = 2
) (
  input logic clk,
  input logic reset,
  mont_cmd_controller_if.slave bus
);
  localparam int BW = WORD_LEN * NUM_CORES;
  state_e r_state;
  logic [3:0] r_op, w_cmd_op;
  logic [NUM_CORES-1:0] r_mask, r_flags, r_start, r_dout_valid, w_raw_mask, w_cmd_mask, w_done;
  logic r_err, r_busy, r_p2_valid, r_mode, w_exec_done, w_unused;
  logic [CYCLE_W-1:0] r_cycles;
  logic [BW-1:0] w_x, w_e, w_m, w_r2m, w_rm, w_res;
  assign w_unused = ^bus.port1_din;
  assign w_cmd_op = bus.port1_din[CMD_OP_LSB +: CMD_OP_W];
  assign w_raw_mask = bus.port1_din[CMD_MASK_LSB +: NUM_CORES];
  assign w_cmd_mask = (w_raw_mask == '0) ? '1 : w_raw_mask;
  // done pulses during the start cycle belong to no run of ours
  assign w_done = (r_start != '0) ? '0 : bus.core_done & r_mask;
  assign w_exec_done = (r_state == S_EXEC) && ((r_flags | w_done | ~r_mask) == '1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_op <= '0;
      r_mask <= '0;
      r_err <= 1'b0;
      r_cycles <= '0;
      r_flags <= '0;
      r_busy <= 1'b0;
      r_p2_valid <= 1'b0;
      r_start <= '0;
      r_mode <= 1'b0;
      r_dout_valid <= '0;
    end else begin
      r_start <= '0;
      case (r_state)
        S_IDLE: if (bus.port1_valid) begin
          r_op <= w_cmd_op;
          r_mask <= w_cmd_mask;
          r_err <= w_cmd_op > OP_WRITE;
          r_cycles <= '0;
          r_flags <= '0;
          r_busy <= 1'b1;
          if (w_cmd_op <= OP_READ_RM) r_state <= S_LOAD;
          else if (w_cmd_op == OP_EXP || w_cmd_op == OP_MUL) begin
            r_state <= S_EXEC;
            r_start <= w_cmd_mask;
            r_mode <= w_cmd_op == OP_MUL;
          end else if (w_cmd_op == OP_WRITE) begin
            r_state <= S_WRITE;
            r_dout_valid <= w_cmd_mask;
          end else begin
            r_state <= S_DONE;
            r_p2_valid <= 1'b1;
          end
        end
        S_LOAD: if (bus.bram_din_valid) begin
          r_state <= S_DONE;
          r_p2_valid <= 1'b1;
        end
        S_EXEC: begin
          r_cycles <= r_cycles + CYCLE_W'(r_cycles != '1);
          r_flags <= r_flags | w_done;
          if (w_exec_done) begin
            r_state <= S_DONE;
            r_p2_valid <= 1'b1;
          end
        end
        S_WRITE: if (bus.bram_dout_read) begin
          r_dout_valid <= '0;
          r_state <= S_DONE;
          r_p2_valid <= 1'b1;
        end
        S_DONE: if (bus.port2_read) begin
          r_p2_valid <= 1'b0;
          r_busy <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    mont_operand_bank #(.WORD_LEN(WORD_LEN)) u_bank (
      .clk(clk),
      .reset(reset),
      .i_we(r_state == S_LOAD && bus.bram_din_valid && r_mask[i]),
      .i_sel(r_op),
      .i_din(bus.bram_din[i*WORD_LEN +: WORD_LEN]),
      .i_res_we(w_exec_done && r_mask[i]),
      .i_res(bus.core_result[i*WORD_LEN +: WORD_LEN]),
      .o_x(w_x[i*WORD_LEN +: WORD_LEN]),
      .o_e(w_e[i*WORD_LEN +: WORD_LEN]),
      .o_m(w_m[i*WORD_LEN +: WORD_LEN]),
      .o_r2m(w_r2m[i*WORD_LEN +: WORD_LEN]),
      .o_rm(w_rm[i*WORD_LEN +: WORD_LEN]),
      .o_result(w_res[i*WORD_LEN +: WORD_LEN])
    );
  end
  assign bus.port1_read = r_busy;
  assign bus.busy = r_busy;
  assign bus.port2_valid = r_p2_valid;
  assign bus.port2_dout = status_word(r_cycles, r_err, r_op);
  assign bus.bram_dout = w_res;
  assign bus.bram_dout_valid = r_dout_valid;
  assign bus.core_start = r_start;
  assign bus.core_mode = r_mode;
  assign bus.core_x = w_x;
  assign bus.core_e = w_e;
  assign bus.core_m = w_m;
  assign bus.core_r2m = w_r2m;
  assign bus.core_rm = w_rm;
endmodule

// File: tb/tb_mont_cmd_controller.sv
// tb_mont_cmd_controller: randomized command sequences checked every cycle against a transaction-level model
`timescale 1ns/1ps
module tb_mont_cmd_controller;
  localparam int W = 512;
  localparam int N = 2;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  mont_cmd_controller_if #(.WORD_LEN(W), .NUM_CORES(N)) bus();
  mont_cmd_controller #(.WORD_LEN(W), .NUM_CORES(N)) dut (.clk(clk), .reset(reset), .bus(bus));
  int total = 0;
  int bad = 0;
  logic [W-1:0] m_ops [N][5];
  logic [W-1:0] m_res [N];
  logic m_busy, m_p2v, m_mode, seen_mode;
  logic [N-1:0] m_start, m_dv, seen_start, seen_dv;
  logic [31:0] m_status, last_status, c;
  logic [W-1:0] x, v, a, prev;
  logic [N*W-1:0] ov [5];
  string nms [5] = '{"x", "e", "m", "r2m", "rm"};
  assign ov[0] = bus.core_x;
  assign ov[1] = bus.core_e;
  assign ov[2] = bus.core_m;
  assign ov[3] = bus.core_r2m;
  assign ov[4] = bus.core_rm;
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  function automatic logic [N*W-1:0] rnd_bus();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = rnd_word();
    return r;
  endfunction
  // stand-in for the real cores: any deterministic mix of the operands is enough
  function automatic logic [W-1:0] core_fn(input int i, input logic mode);
    return mode ? (m_ops[i][0] ^ m_ops[i][1]) + m_ops[i][2]
                : (m_ops[i][0] + m_ops[i][1]) ^ m_ops[i][2] ^ m_ops[i][3] ^ m_ops[i][4];
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic quiet();
    bus.port1_valid = 1'b0;
    bus.bram_din_valid = 1'b0;
    bus.bram_dout_read = 1'b0;
    bus.port2_read = 1'b0;
    bus.core_done = '0;
  endtask
  task automatic zero_model();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < 5; j++) m_ops[i][j] = '0;
      m_res[i] = '0;
    end
    m_busy = 1'b0;
    m_p2v = 1'b0;
    m_start = '0;
    m_dv = '0;
    m_mode = 1'b0;
    m_status = '0;
  endtask
  always @(negedge clk) begin
    chk("busy", W'(bus.busy), W'(m_busy));
    chk("port1_read", W'(bus.port1_read), W'(m_busy));
    chk("port2_valid", W'(bus.port2_valid), W'(m_p2v));
    if (m_p2v) chk("port2_dout", W'(bus.port2_dout), W'(m_status));
    chk("core_start", W'(bus.core_start), W'(m_start));
    if (m_start != '0) chk("core_mode", W'(bus.core_mode), W'(m_mode));
    chk("bram_dout_valid", W'(bus.bram_dout_valid), W'(m_dv));
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < 5; j++) chk($sformatf("core_%s[%0d]", nms[j], i), ov[j][i*W +: W], m_ops[i][j]);
      chk($sformatf("bram_dout[%0d]", i), bus.bram_dout[i*W +: W], m_res[i]);
    end
  end
  task automatic do_cmd(input logic [31:0] cmd, input logic [N*W-1:0] d, input int l0, input int l1,
                        input int abort_at, input bit hold2);
    logic [3:0] op;
    logic [N-1:0] msk;
    int lat [N];
    int kend;
    op = cmd[3:0];
    msk = (cmd[8 +: N] == '0) ? '1 : cmd[8 +: N];
    lat[0] = l0;
    lat[1] = l1;
    bus.port1_din = cmd;
    bus.port1_valid = 1'b1;
    tick();
    bus.port1_valid = 1'b0;
    m_busy = 1'b1;
    if (op <= 4) begin
      repeat ($urandom_range(0, 2)) begin
        bus.port1_valid = 1'b1;
        bus.port1_din = $urandom;
        bus.bram_dout_read = 1'b1;
        bus.port2_read = 1'b1;
        tick();
      end
      quiet();
      bus.bram_din = d;
      bus.bram_din_valid = 1'b1;
      tick();
      bus.bram_din_valid = 1'b0;
      for (int i = 0; i < N; i++) if (msk[i]) m_ops[i][op[2:0]] = d[i*W +: W];
      m_status = {16'd0, 7'd0, 1'b0, 4'd0, op};
      m_p2v = 1'b1;
    end else if (op == 5 || op == 6) begin
      m_start = msk;
      m_mode = op == 6;
      seen_start = bus.core_start;
      seen_mode = bus.core_mode;
      kend = 0;
      for (int i = 0; i < N; i++) if (msk[i] && lat[i] > kend) kend = lat[i];
      tick();
      m_start = '0;
      for (int k = 1; k <= kend; k++) begin
        bus.bram_din_valid = 1'($urandom_range(0, 1));
        bus.bram_din = rnd_bus();
        bus.port2_read = 1'($urandom_range(0, 1));
        bus.bram_dout_read = 1'($urandom_range(0, 1));
        bus.port1_valid = 1'($urandom_range(0, 1));
        bus.port1_din = $urandom;
        for (int i = 0; i < N; i++) if (lat[i] == k) begin
          bus.core_done[i] = 1'b1;
          bus.core_result[i*W +: W] = core_fn(i, op == 6);
        end
        if (k == abort_at) begin
          quiet();
          reset = 1'b1;
          zero_model();
          #1;
          chk("abort_port1_read", W'(bus.port1_read), '0);
          chk("abort_port2_valid", W'(bus.port2_valid), '0);
          chk("abort_core_x0", bus.core_x[0 +: W], '0);
          tick();
          reset = 1'b0;
          return;
        end
        tick();
        bus.core_done = '0;
      end
      quiet();
      for (int i = 0; i < N; i++) if (msk[i]) m_res[i] = core_fn(i, op == 6);
      m_status = {16'(kend + 1), 7'd0, 1'b0, 4'd0, op};
      m_p2v = 1'b1;
    end else if (op == 7) begin
      m_dv = msk;
      seen_dv = bus.bram_dout_valid;
      repeat ($urandom_range(0, 2)) begin
        bus.bram_din_valid = 1'b1;
        bus.bram_din = rnd_bus();
        bus.port2_read = 1'b1;
        tick();
      end
      quiet();
      bus.bram_dout_read = 1'b1;
      tick();
      bus.bram_dout_read = 1'b0;
      m_dv = '0;
      m_status = {16'd0, 7'd0, 1'b0, 4'd0, op};
      m_p2v = 1'b1;
    end else begin
      m_status = {16'd0, 7'd0, 1'b1, 4'd0, op};
      m_p2v = 1'b1;
    end
    last_status = bus.port2_dout;
    repeat ($urandom_range(0, 2)) begin
      bus.bram_din_valid = 1'b1;
      bus.bram_din = rnd_bus();
      bus.bram_dout_read = 1'b1;
      tick();
    end
    quiet();
    bus.port2_read = 1'b1;
    tick();
    m_p2v = 1'b0;
    m_busy = 1'b0;
    if (hold2) tick();
    bus.port2_read = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    quiet();
    bus.port1_din = '0;
    bus.bram_din = '0;
    bus.core_result = '0;
    zero_model();
    repeat (3) tick();
    chk("reset_port2_dout", W'(bus.port2_dout), '0);
    chk("reset_core_start", W'(bus.core_start), '0);
    reset = 1'b0;
    tick();
    x = rnd_word();
    x[W-1 -: 16] = 16'hba61;
    x[15:0] = 16'h8e33;
    do_cmd(32'h0, {x, x}, 0, 0, 0, 0);
    v = W'(8'ha1);
    do_cmd(32'h1, {v, v}, 0, 0, 0, 0);
    for (int j = 2; j < 5; j++) begin
      v = rnd_word();
      do_cmd(32'(j), {v, v}, 0, 0, 0, 0);
    end
    do_cmd(32'h5, '0, 100, 100, 0, 0);
    chk("exp_start", W'(seen_start), W'(2'b11));
    chk("exp_cycles", W'(last_status[31:16]), W'(16'd101));
    do_cmd(32'h7, '0, 0, 0, 0, 0);
    chk("write_valid", W'(seen_dv), W'(2'b11));
    chk("write_res_equal", bus.bram_dout[W +: W], bus.bram_dout[0 +: W] ^ '0 | core_fn(1, 1'b0));
    chk("write_res0", bus.bram_dout[0 +: W], core_fn(0, 1'b0));
    for (int j = 0; j < 3; j++) do_cmd(32'h0100 | 32'(j), rnd_bus(), 0, 0, 0, 0);
    do_cmd(32'h0106, '0, 30, 10, 0, 0);
    chk("mul_start", W'(seen_start), W'(2'b01));
    chk("mul_mode", W'(seen_mode), W'(1'b1));
    do_cmd(32'h0107, '0, 0, 0, 0, 0);
    chk("mul_write_valid", W'(seen_dv), W'(2'b01));
    prev = m_ops[0][0];
    a = rnd_word();
    do_cmd(32'h0200, {a, rnd_word()}, 0, 0, 0, 0);
    chk("readx_core0_kept", bus.core_x[0 +: W], prev);
    chk("readx_core1_new", bus.core_x[W +: W], a);
    do_cmd(32'h9, '0, 0, 0, 0, 0);
    chk("illegal_status", W'(last_status), W'(32'h0000_0109));
    do_cmd(32'h5, '0, 50, 50, 10, 0);
    do_cmd(32'h5, '0, 3, 7, 0, 0);
    chk("post_reset_cycles", W'(last_status), W'(32'h0008_0005));
    do_cmd(32'h5, '0, 5, 40, 0, 1);
    chk("spread_status", W'(last_status), W'(32'h0029_0005));
    for (int n = 0; n < 40; n++) begin
      c = $urandom;
      c[3:0] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      do_cmd(c, rnd_bus(), $urandom_range(1, 40), $urandom_range(1, 40), 0, 1'($urandom_range(0, 1)));
    end
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
